// File: rtl/regfile_write_ctrl_if.sv
// Write-port bundle between the two writeback requesters,
// the write controller and the register file.
interface regfile_write_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_dest;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_dest;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              regWrite;
    logic [ADDR_W-1:0] regDest;
    logic [DATA_W-1:0] writeData;
    logic              init_busy;

    modport master (
        output a_valid, a_dest, a_data,
        output b_valid, b_dest, b_data,
        input  a_ready, b_ready,
        input  regWrite, regDest, writeData, init_busy
    );

    modport slave (
        input  a_valid, a_dest, a_data,
        input  b_valid, b_dest, b_data,
        output a_ready, b_ready,
        output regWrite, regDest, writeData, init_busy
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Round-robin write-port arbiter for the register file, with a
// post-reset sweep that zeroes registers 1..NREGS-1.
module regfile_write_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_write_ctrl_if.slave  bus
);
    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(NREGS-1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              last_b_q, last_b_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              run;
    logic              grant_a;
    logic              grant_b;

    // On a tie the requester that did not win last time goes first.
    assign run     = (state_q == S_RUN);
    assign grant_a = run && bus.a_valid && (!bus.b_valid || last_b_q);
    assign grant_b = run && bus.b_valid && (!bus.a_valid || !last_b_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        we_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        unique case (state_q)
            S_CLEAR: begin
                we_d   = 1'b1;
                dest_d = cnt_q[ADDR_W-1:0];
                data_d = '0;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Writes to r0 are accepted but never reach the file.
                if (grant_a) begin
                    last_b_d = 1'b0;
                    dest_d   = bus.a_dest;
                    data_d   = bus.a_data;
                    we_d     = |bus.a_dest;
                end else if (grant_b) begin
                    last_b_d = 1'b1;
                    dest_d   = bus.b_dest;
                    data_d   = bus.b_data;
                    we_d     = |bus.b_dest;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_CLEAR;
            cnt_q    <= CNT_ONE;
            last_b_q <= 1'b1;
            we_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.regWrite  = we_q;
    assign bus.regDest   = dest_q;
    assign bus.writeData = data_q;
    assign bus.init_busy = ~run;
endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32 x 32 register file. It arbitrates two writeback requesters, A (ALU) and B (load unit), onto the register file's single write port (`regWrite`, `regDest`, `writeData`) using round-robin priority. After reset it runs a clear sequence that writes zero to registers 1..NREGS-1, so reads never return X. It sits between the writeback stage and the register file. Its outputs connect directly to the register file's write inputs, which the register file samples on the falling clock edge.

## Interface
- `DATA_W`, 32, data width of the write port
- `ADDR_W`, 5, register address width
- `NREGS`, 32, number of registers; clear sequence covers 1..NREGS-1

- `clock`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `a_valid`  in  1  requester A has a write pending
- `a_dest`  in  ADDR_W  A destination register
- `a_data`  in  DATA_W  A write data
- `a_ready`  out  1  A granted this cycle (transfer when `a_valid && a_ready`)
- `b_valid`, `b_dest`, `b_data`, `b_ready`: same as A, for requester B
- `regWrite`  out  1  write enable to register file (registered)
- `regDest`  out  ADDR_W  write address to register file (registered)
- `writeData`  out  DATA_W  write data to register file (registered)
- `init_busy`  out  1  high while clear sequence is running

## Operation
- **State machine**: CLEAR -> RUN. There is no other exit from CLEAR, and RUN exits only via `reset`.
- **Reset values**:
  - state = CLEAR, clear counter `cnt` = 1, `last_grant` = B
  - `regWrite`, `regDest`, `writeData` = 0
  - `a_ready`, `b_ready` = 0
  - `init_busy` = 1
- **CLEAR**:
  - Each posedge: `regWrite`<=1, `regDest`<=`cnt`, `writeData`<=0, `cnt`<=`cnt`+1.
  - At the posedge where `cnt`==NREGS-1, the last clear write is issued and state<=RUN.
  - `a_ready` = `b_ready` = 0 throughout.
  - `init_busy` = (state==CLEAR).
- **RUN grant** (combinational from the valids and `last_grant`):
  - Only A valid -> A granted. Only B valid -> B granted.
  - Both valid -> grant the requester that is not `last_grant`.
  - Neither valid -> no grant.
- **Transfer** (posedge with a grant):
  - `last_grant`<=granted requester.
  - `regDest`<=dest, `writeData`<=data.
  - `regWrite`<=1 if dest != 0; if dest == 0, `regWrite`<=0. The write is accepted and discarded.
- **No transfer**: `regWrite`<=0; `regDest` and `writeData` hold.
- **Same destination in the same cycle**: no special handling. The round-robin loser is written in a later cycle, so the later grant's value ends up in the register.
- **Width rules**: `cnt` is ADDR_W+1 bits so the end compare does not wrap. Dest and data pass through unmodified.
- **Reset mid-operation** (CLEAR or RUN):
  - Outputs return to their reset values asynchronously.
  - Any in-flight request is not accepted.
  - The clear sequence restarts at register 1 after `reset` deasserts.

## Timing
- **Clear duration**: NREGS-1 = 31 posedges after `reset` deasserts.
  - `regDest` steps 1..31 with `regWrite` held high for 31 consecutive cycles.
  - `init_busy` falls at the same posedge that issues the write to register 31.
  - Grants are possible from the following cycle.
- **Grant to write-port latency**: 1 cycle.
  - A transfer at posedge k drives `regWrite`/`regDest`/`writeData` during cycle k..k+1.
  - The register file captures the write at the negedge mid-cycle.
  - Read ports see the new value from that negedge onward.
- **Throughput**: one write per cycle; back-to-back grants give continuous `regWrite`.
- **Under contention**: a requester holding `valid` waits at most one cycle for its grant.
- **Timing paths**:
  - `a_ready`/`b_ready` are combinational from `a_valid`, `b_valid`, state and `last_grant`.
  - There is no combinational path from any input to `regWrite`, `regDest` or `writeData`.
- **Request stability**: a requester holds `valid`, dest and data stable until it sees `ready`.

## Test plan
- **Reset release**: deassert `reset` with no requests.
  - `regWrite`=1 for 31 cycles, `regDest`=1,2,...,31, `writeData`=0.
  - `init_busy` drops after the 31st posedge; `a_ready`/`b_ready` stay 0 during clear.
  - After the sequence, reading registers 1..31 returns 0.
- **A only**: `a_valid`=1, `a_dest`=5, `a_data`=0x12345678 for one cycle.
  - `a_ready`=1 in that cycle.
  - Next cycle: `regWrite`=1, `regDest`=5, `writeData`=0x12345678.
  - Following cycle: `regWrite`=0; a read of register 5 returns 0x12345678.
- **Contention**: A (dest 3, data 0xA) and B (dest 4, data 0xB) both held valid for 4 cycles.
  - Grants go A, B, A, B; `regDest` sequence 3, 4, 3, 4.
  - `regWrite` stays high for 4 cycles.
- **Zero destination**: B valid with `b_dest`=0, `b_data`=0xFFFFFFFF.
  - `b_ready`=1 and `regWrite` stays 0.
  - A following tie is granted to A (`last_grant` updated to B).
  - A read of register 0 returns 0.
- **Reset mid-clear**: assert `reset` while `regDest`=10.
  - `regWrite`, `regDest`, `writeData` go to 0 immediately; `init_busy`=1.
  - After release, `regDest` restarts at 1 and runs the full 31-cycle clear.
- **Back-to-back A, B idle**: A valid for 3 cycles, dest 7/8/9, data 1/2/3.
  - `regWrite` high 3 consecutive cycles with matching dest/data.
  - Registers 7, 8, 9 read back 1, 2, 3.
